wb_multi_port_arbiter: RTL
==========================

WB_MULTI_PORT_ARBITER -- requirements
Module: wb_multi_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 3, number of Wishbone master ports (1..16).
REQ-002 SHALL have parameter WORD_SIZE, default 256, data width in bits.
REQ-003 SHALL have parameter ADDR_WIDTH, default 32, address width in bits.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port wishbone_cyc_i  input  NUM_PORTS  per-port bus cycle.
REQ-007 SHALL have port wishbone_stb_i  input  NUM_PORTS  per-port strobe.
REQ-008 SHALL have port wishbone_we_i  input  NUM_PORTS  per-port write enable.
REQ-009 SHALL have port wishbone_addr_i  input  NUM_PORTS*ADDR_WIDTH  packed addresses, port p at bits [p*ADDR_WIDTH +: ADDR_WIDTH].
REQ-010 SHALL have port wishbone_mosi_i  input  NUM_PORTS*WORD_SIZE  packed write data, same packing.
REQ-011 SHALL have port wishbone_ack_o  output  NUM_PORTS  per-port acknowledge.
REQ-012 SHALL have port wishbone_miso_o  output  WORD_SIZE  read data, shared by all ports, valid with any ack.
REQ-013 SHALL have ports memory_cyc_o, memory_stb_o, memory_we_o  output  1 each  downstream request.
REQ-014 SHALL have ports memory_addr_o  output  ADDR_WIDTH and memory_mosi_o  output  WORD_SIZE.
REQ-015 SHALL have ports memory_ack_i  input  1 and memory_miso_i  input  WORD_SIZE.
REQ-016 SHALL have port grant_o  output  $clog2(NUM_PORTS) (min 1)  index of port owning the current transaction.

Function
REQ-017 SHALL register every output; no combinational path from any input to any output.
REQ-018 SHALL implement FSM IDLE -> ISSUE -> RESPOND -> IDLE.
REQ-019 IDLE: a port requests when cyc_i & stb_i; if any request exists, SHALL latch winner index, addr, mosi, we and enter ISSUE next cycle.
REQ-020 ISSUE: memory_cyc_o = memory_stb_o = 1 with latched fields held stable until memory_ack_i = 1.
REQ-021 On memory_ack_i in ISSUE: SHALL deassert memory_cyc_o/stb_o, latch memory_miso_i, enter RESPOND.
REQ-022 RESPOND: wishbone_ack_o[grant] = 1 for exactly one cycle, wishbone_miso_o = latched data; then IDLE.
REQ-023 Latency: request sampled in IDLE at cycle N -> memory_stb_o at N+1; memory_ack_i at cycle M -> wishbone_ack_o at M+1.
REQ-024 Minimum throughput: one transaction per 3 cycles (zero-wait memory).
REQ-025 Granted master dropping cyc_i during ISSUE: transaction still completes downstream; RESPOND asserts no ack; miso discarded.
REQ-026 Masters SHALL drop stb_i the cycle after ack; a port still requesting when IDLE re-entered is treated as a new request.
REQ-027 memory_ack_i outside ISSUE SHALL be ignored.
REQ-028 Requests arriving during ISSUE/RESPOND wait; no request is lost while cyc_i & stb_i remain high.
REQ-029 NUM_PORTS = 1: arbitration degenerates to pass-through of port 0 with same FSM timing; grant_o = 0.

Reset
REQ-030 While rst_n = 0, regardless of clk: FSM = IDLE, all memory_* outputs 0, wishbone_ack_o 0, wishbone_miso_o 0, grant_o 0, priority pointer 0.
REQ-031 Reset during ISSUE SHALL abandon the transaction immediately; no ack is issued after release.

Configuration
REQ-032 Macro WB_ARB_ROUND_ROBIN_EN defined: round-robin; highest priority is port (last_grant+1) mod NUM_PORTS, wrapping NUM_PORTS-1 -> 0; pointer updates only on entry to ISSUE.
REQ-033 Macro undefined: fixed priority, lowest index wins; pointer logic absent.

Verification
REQ-034 Single request: port 1 read addr 0x40, memory acks 2 cycles after stb with 0xA5.. -> memory_addr_o 0x40, we 0, wishbone_ack_o = 3'b010 one cycle, miso 0xA5...
REQ-035 Simultaneous requests ports 0,1,2 held continuously, RR enabled -> grants 0,1,2,0; RR disabled -> grants 0,0,0 while port 0 keeps requesting.
REQ-036 Write: port 2 we=1 mosi 0x1234 addr 0x80 -> memory_we_o 1, memory_mosi_o 0x1234, ack only on bit 2.
REQ-037 Abort: port 0 drops cyc_i mid-ISSUE -> memory cycle completes on ack, wishbone_ack_o stays 0, FSM returns IDLE.
REQ-038 Reset asserted asynchronously in ISSUE -> memory_stb_o 0 before next clk edge, no ack after release.
REQ-039 Spurious memory_ack_i in IDLE -> no state change, all acks 0.

Source files
------------

// File: rtl/wb_multi_port_arbiter.sv
// ---------------------------------------------------------------------------
// wb_multi_port_arbiter
//
// Shares one downstream Wishbone memory port between NUM_PORTS upstream
// masters. Each transaction runs IDLE -> ISSUE -> RESPOND -> IDLE, so with a
// zero-wait memory one transaction completes every three cycles. Every output
// is driven straight from a flop.
//
// Build option:
//   WB_ARB_ROUND_ROBIN_EN  defined   : round-robin arbitration. The priority
//                                      pointer names the highest-priority
//                                      port and moves to winner+1 (mod
//                                      NUM_PORTS) each time a transaction is
//                                      issued.
//                          undefined : fixed priority, lowest index wins.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   wishbone_cyc_i      per-port bus cycle
//   wishbone_stb_i      per-port strobe
//   wishbone_we_i       per-port write enable
//   wishbone_addr_i     packed addresses, port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
//   wishbone_mosi_i     packed write data, port p at [p*WORD_SIZE +: WORD_SIZE]
//   wishbone_ack_o      per-port one-cycle acknowledge
//   wishbone_miso_o     read data shared by all ports, valid with any ack
//   memory_cyc_o/stb_o  downstream request (both high for the whole ISSUE)
//   memory_we_o         downstream write enable
//   memory_addr_o       downstream address
//   memory_mosi_o       downstream write data
//   memory_ack_i        downstream acknowledge (ignored outside ISSUE)
//   memory_miso_i       downstream read data
//   grant_o             index of the port owning the current transaction
// ---------------------------------------------------------------------------
module wb_multi_port_arbiter #(
    parameter int NUM_PORTS  = 3,
    parameter int WORD_SIZE  = 256,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                                                 clk,
    input  logic                                                 rst_n,
    input  logic [NUM_PORTS-1:0]                                 wishbone_cyc_i,
    input  logic [NUM_PORTS-1:0]                                 wishbone_stb_i,
    input  logic [NUM_PORTS-1:0]                                 wishbone_we_i,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]                      wishbone_addr_i,
    input  logic [NUM_PORTS*WORD_SIZE-1:0]                       wishbone_mosi_i,
    output logic [NUM_PORTS-1:0]                                 wishbone_ack_o,
    output logic [WORD_SIZE-1:0]                                 wishbone_miso_o,
    output logic                                                 memory_cyc_o,
    output logic                                                 memory_stb_o,
    output logic                                                 memory_we_o,
    output logic [ADDR_WIDTH-1:0]                                memory_addr_o,
    output logic [WORD_SIZE-1:0]                                 memory_mosi_o,
    input  logic                                                 memory_ack_i,
    input  logic [WORD_SIZE-1:0]                                 memory_miso_i,
    output logic [((NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1)-1:0] grant_o
);

    localparam int GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_RESPOND = 2'd2
    } state_t;

    // Index of the lowest set bit of v (0 when v is empty).
    function automatic logic [GW-1:0] pick_lowest(input logic [NUM_PORTS-1:0] v);
        logic [GW-1:0] idx;
        idx = {GW{1'b0}};
        for (int p = NUM_PORTS - 1; p >= 0; p--) begin
            if (v[p]) begin
                idx = GW'(p);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // One-hot vector with only bit idx set.
    function automatic logic [NUM_PORTS-1:0] one_hot(input logic [GW-1:0] idx);
        logic [NUM_PORTS-1:0] v;
        v = {NUM_PORTS{1'b0}};
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (GW'(p) == idx) begin
                v[p] = 1'b1;
            end else begin
                v[p] = 1'b0;
            end
        end
        return v;
    endfunction

    state_t                  state_r,  state_nxt_s;
    logic [GW-1:0]           grant_r,  grant_nxt_s;
    logic [ADDR_WIDTH-1:0]   addr_r,   addr_nxt_s;
    logic [WORD_SIZE-1:0]    mosi_r,   mosi_nxt_s;
    logic                    we_r,     we_nxt_s;
    logic                    mreq_r,   mreq_nxt_s;
    logic [WORD_SIZE-1:0]    miso_r,   miso_nxt_s;
    logic [NUM_PORTS-1:0]    ack_r,    ack_nxt_s;
    logic                    abort_r,  abort_nxt_s;
    logic                    abort_s;

    logic [NUM_PORTS-1:0]    req_s;
    logic [GW-1:0]           win_s;
    logic [ADDR_WIDTH-1:0]   sel_addr_s;
    logic [WORD_SIZE-1:0]    sel_mosi_s;
    logic                    sel_we_s;

`ifdef WB_ARB_ROUND_ROBIN_EN
    logic [GW-1:0]           ptr_r,    ptr_nxt_s;
    logic [NUM_PORTS-1:0]    mask_s;
`endif

    // Winner selection and the winner's request fields.
    always_comb begin
        req_s = wishbone_cyc_i & wishbone_stb_i;
`ifdef WB_ARB_ROUND_ROBIN_EN
        // Ports at or above the pointer are searched first, then wrap to 0.
        mask_s = {NUM_PORTS{1'b0}};
        for (int p = 0; p < NUM_PORTS; p++) begin
            mask_s[p] = (p >= int'(ptr_r));
        end
        if ((req_s & mask_s) != {NUM_PORTS{1'b0}}) begin
            win_s = pick_lowest(req_s & mask_s);
        end else begin
            win_s = pick_lowest(req_s);
        end
`else
        win_s = pick_lowest(req_s);
`endif
        sel_addr_s = {ADDR_WIDTH{1'b0}};
        sel_mosi_s = {WORD_SIZE{1'b0}};
        sel_we_s   = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (win_s == GW'(p)) begin
                sel_addr_s = wishbone_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
                sel_mosi_s = wishbone_mosi_i[p*WORD_SIZE +: WORD_SIZE];
                sel_we_s   = wishbone_we_i[p];
            end else begin
                sel_addr_s = sel_addr_s;
                sel_mosi_s = sel_mosi_s;
                sel_we_s   = sel_we_s;
            end
        end
    end

    // FSM next-state and next values of every output register.
    always_comb begin
        state_nxt_s = state_r;
        grant_nxt_s = grant_r;
        addr_nxt_s  = addr_r;
        mosi_nxt_s  = mosi_r;
        we_nxt_s    = we_r;
        mreq_nxt_s  = mreq_r;
        miso_nxt_s  = miso_r;
        ack_nxt_s   = {NUM_PORTS{1'b0}};
        abort_nxt_s = abort_r;
`ifdef WB_ARB_ROUND_ROBIN_EN
        ptr_nxt_s   = ptr_r;
`endif
        // The owner has abandoned the transaction if it dropped cyc at any
        // point during ISSUE, including the cycle the memory acknowledges.
        abort_s     = abort_r | ~wishbone_cyc_i[grant_r];

        case (state_r)
            ST_IDLE: begin
                if (req_s != {NUM_PORTS{1'b0}}) begin
                    state_nxt_s = ST_ISSUE;
                    grant_nxt_s = win_s;
                    addr_nxt_s  = sel_addr_s;
                    mosi_nxt_s  = sel_mosi_s;
                    we_nxt_s    = sel_we_s;
                    mreq_nxt_s  = 1'b1;
                    abort_nxt_s = 1'b0;
`ifdef WB_ARB_ROUND_ROBIN_EN
                    if (int'(win_s) == NUM_PORTS - 1) begin
                        ptr_nxt_s = {GW{1'b0}};
                    end else begin
                        ptr_nxt_s = win_s + GW'(1);
                    end
`endif
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (memory_ack_i) begin
                    state_nxt_s = ST_RESPOND;
                    mreq_nxt_s  = 1'b0;
                    if (abort_s) begin
                        // Data for a departed master is dropped.
                        ack_nxt_s  = {NUM_PORTS{1'b0}};
                        miso_nxt_s = miso_r;
                    end else begin
                        ack_nxt_s  = one_hot(grant_r);
                        miso_nxt_s = memory_miso_i;
                    end
                end else begin
                    abort_nxt_s = abort_s;
                end
            end
            ST_RESPOND: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                mreq_nxt_s  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            grant_r <= {GW{1'b0}};
            addr_r  <= {ADDR_WIDTH{1'b0}};
            mosi_r  <= {WORD_SIZE{1'b0}};
            we_r    <= 1'b0;
            mreq_r  <= 1'b0;
            miso_r  <= {WORD_SIZE{1'b0}};
            ack_r   <= {NUM_PORTS{1'b0}};
            abort_r <= 1'b0;
`ifdef WB_ARB_ROUND_ROBIN_EN
            ptr_r   <= {GW{1'b0}};
`endif
        end else begin
            state_r <= state_nxt_s;
            grant_r <= grant_nxt_s;
            addr_r  <= addr_nxt_s;
            mosi_r  <= mosi_nxt_s;
            we_r    <= we_nxt_s;
            mreq_r  <= mreq_nxt_s;
            miso_r  <= miso_nxt_s;
            ack_r   <= ack_nxt_s;
            abort_r <= abort_nxt_s;
`ifdef WB_ARB_ROUND_ROBIN_EN
            ptr_r   <= ptr_nxt_s;
`endif
        end
    end

    assign wishbone_ack_o  = ack_r;
    assign wishbone_miso_o = miso_r;
    assign memory_cyc_o    = mreq_r;
    assign memory_stb_o    = mreq_r;
    assign memory_we_o     = we_r;
    assign memory_addr_o   = addr_r;
    assign memory_mosi_o   = mosi_r;
    assign grant_o         = grant_r;

endmodule
